d_cache: RTL
============

# d_cache

Direct-mapped, write-back, write-allocate data cache between the MEM/WB-stage data access and main memory. It produces `DCacheMiss` for the pipeline hazard unit, which stalls every stage while it is high. Hits complete in the access cycle with no stall. Misses run a line write-back and/or line refill over a word-serial memory handshake, then the cache services the held request as a hit.

## Interface
Parameters:
- `LINE_ADDR_LEN`, 3: log2 of words per line (8 words).
- `SET_ADDR_LEN`, 3: log2 of number of lines (8 lines).
- `TAG_ADDR_LEN`, 32-2-LINE_ADDR_LEN-SET_ADDR_LEN: tag width (derived; do not override).

Ports:
- `clk`  in  1  the single clock; all state updates on rising edge.
- `CpuRstN`  in  1  reset; synchronous, active-low.
- `RdReq`  in  1  word read request from pipeline.
- `WrReq`  in  1  word write request from pipeline.
- `Addr`  in  32  byte address; `Addr[1:0]` ignored (word accesses only).
- `WrData`  in  32  store data.
- `RdData`  out  32  load data; valid in any cycle with read hit.
- `DCacheMiss`  out  1  stall request to hazard unit.
- `MemRdReq`  out  1  main-memory word read request.
- `MemWrReq`  out  1  main-memory word write request.
- `MemAddr`  out  32  word-aligned memory address.
- `MemWrData`  out  32  memory write data.
- `MemRdData`  in  32  memory read data; valid when `MemGnt`=1.
- `MemGnt`  in  1  memory completes the current word this cycle.

## Operation
- Address split: `Addr[31:32-TAG]` tag | set | word offset (`LINE_ADDR_LEN`) | `Addr[1:0]`.
- Per line: `valid`, `dirty`, tag, and 2^LINE_ADDR_LEN words.
- Hit = state IDLE & `valid[set]` & tag match.
- `WrReq` and `RdReq` high together: treated as write; `RdData`=0.
- State machine:
  - IDLE:
    - Read hit: `RdData` = stored word (combinational).
    - Write hit: word written at edge; `dirty[set]`=1.
    - Request & !hit: if victim valid&dirty → SWAP_OUT, else → SWAP_IN. Word counter cleared.
  - SWAP_OUT:
    - `MemWrReq`=1, `MemAddr`={victim tag, set, cnt, 2'b00}, `MemWrData`=victim word[cnt].
    - On `MemGnt`: cnt++. After last word, cnt wraps to 0 → SWAP_IN.
  - SWAP_IN:
    - `MemRdReq`=1, `MemAddr`={req tag, set, cnt, 2'b00}.
    - On `MemGnt`: `MemRdData` written into line word[cnt], cnt++. After last word → SWAP_IN_OK.
  - SWAP_IN_OK: tag←req tag, `valid`=1, `dirty`=0 → IDLE.
- `DCacheMiss` = (state≠IDLE) | ((`RdReq`|`WrReq`) & !hit).
- The pipeline holds `Addr`/`WrData`/request stable while `DCacheMiss`=1; cache behaviour is undefined otherwise.
- `MemRdReq` and `MemWrReq` are never high together. Each stays high, with address and data stable, until `MemGnt`.
- `MemGnt` outside SWAP_OUT/SWAP_IN is ignored.
- Outputs when idle: `RdData`=0 when no read hit; `MemRdReq`/`MemWrReq`=0; `MemAddr`/`MemWrData`=0.

## Timing
- Reset (`CpuRstN`=0 at edge): state=IDLE, cnt=0, all `valid`/`dirty` cleared. Data arrays are not cleared.
- While `CpuRstN`=0: `DCacheMiss`=0, `RdData`=0, `MemRdReq`=`MemWrReq`=0, `MemAddr`=`MemWrData`=0.
- Reset mid-refill/write-back: operation aborted at that edge. The memory request drops and partial line data is discarded; the line stays invalid.
- Hit latency: 0 (same cycle, no stall).
- Clean miss with `MemGnt` tied high: `DCacheMiss` high for 1 + 2^L + 1 cycles (10 at default), then low in the hit cycle.
- Dirty miss adds 2^L cycles (18 at default). Each cycle of `MemGnt` low adds one cycle.
- The word counter is `LINE_ADDR_LEN` bits wide and wraps naturally.

## Test plan
- Reset, then `RdReq`=1 `Addr`=0x0000_0040 with `MemGnt`=1 and memory word = address → `DCacheMiss`=1 for 10 cycles; `MemAddr` steps 0x40..0x5C; then `RdData`=0x0000_0040, `DCacheMiss`=0.
- Read 0x44 after that fill → `DCacheMiss`=0 same cycle, `RdData`=0x44, no memory request.
- Write hit 0x48←0xDEAD_BEEF; then read 0x0000_0448 (same set, new tag):
  - 8 writes 0x40..0x5C occur first, with 0xDEADBEEF at 0x48.
  - Then 8 reads at 0x440..0x45C.
  - `DCacheMiss` high 18 cycles.
- Refill with `MemGnt` low 2 of every 3 cycles → address/request stable while waiting; miss length 1+24+1 = 26 cycles.
- Drop `CpuRstN` during SWAP_IN word 3 → next cycle all `Mem*Req`=0 and state IDLE. A following read of the same address misses again (full 10-cycle refill).
- `RdReq`=`WrReq`=1 on a hit → write performed, `RdData`=0, line marked dirty (verified by a later eviction write-back).

Source files
------------

// File: rtl/d_cache.sv
// Direct-mapped write-back, write-allocate data cache with word-serial line
// write-back and refill against main memory; stalls the pipeline on a miss.
module d_cache #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 3,
    parameter int TAG_ADDR_LEN  = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
    input  logic        clk,
    input  logic        CpuRstN,
    input  logic        RdReq,
    input  logic        WrReq,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    output logic [31:0] RdData,
    output logic        DCacheMiss,
    output logic        MemRdReq,
    output logic        MemWrReq,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWrData,
    input  logic [31:0] MemRdData,
    input  logic        MemGnt
);
    // state      | meaning
    // IDLE       | serve hits, detect misses
    // SWAP_OUT   | write dirty victim line back, one word per grant
    // SWAP_IN    | refill line from memory, one word per grant
    // SWAP_IN_OK | commit tag/valid, held request then hits in IDLE

    localparam int LINE_WORDS = 1 << LINE_ADDR_LEN;
    localparam int SETS       = 1 << SET_ADDR_LEN;

    typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_e;

    state_e                    state_q, state_d;
    logic [LINE_ADDR_LEN-1:0]  cnt_q, cnt_d;
    logic [SETS-1:0]           valid_q, valid_d;
    logic [SETS-1:0]           dirty_q, dirty_d;
    logic [TAG_ADDR_LEN-1:0]   tag_q  [SETS];
    logic [31:0]               data_q [SETS][LINE_WORDS];

    logic [TAG_ADDR_LEN-1:0]   req_tag;
    logic [SET_ADDR_LEN-1:0]   req_set;
    logic [LINE_ADDR_LEN-1:0]  req_word;
    logic                      req, hit, cnt_last;
    logic                      data_we, tag_we;
    logic [LINE_ADDR_LEN-1:0]  data_wword;
    logic [31:0]               data_wdata;
    logic                      unused_addr_lsb;

    assign req_tag         = Addr[31 -: TAG_ADDR_LEN];
    assign req_set         = Addr[2 + LINE_ADDR_LEN +: SET_ADDR_LEN];
    assign req_word        = Addr[2 +: LINE_ADDR_LEN];
    assign unused_addr_lsb = ^Addr[1:0];
    assign req             = RdReq | WrReq;
    assign hit             = (state_q == IDLE) && valid_q[req_set] && (tag_q[req_set] == req_tag);
    assign cnt_last        = (cnt_q == {LINE_ADDR_LEN{1'b1}});

    always_ff @(posedge clk) begin
        if (!CpuRstN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Arrays carry no reset; writes are suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (CpuRstN) begin
            if (data_we) data_q[req_set][data_wword] <= data_wdata;
            if (tag_we)  tag_q[req_set] <= req_tag;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (req && !hit)
                            state_d = (valid_q[req_set] && dirty_q[req_set]) ? SWAP_OUT : SWAP_IN;
            SWAP_OUT:   if (MemGnt && cnt_last) state_d = SWAP_IN;
            SWAP_IN:    if (MemGnt && cnt_last) state_d = SWAP_IN_OK;
            SWAP_IN_OK: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        data_we    = 1'b0;
        tag_we     = 1'b0;
        data_wword = req_word;
        data_wdata = WrData;
        case (state_q)
            IDLE: begin
                if (req && !hit) cnt_d = '0;
                if (WrReq && hit) begin
                    data_we          = 1'b1;
                    dirty_d[req_set] = 1'b1;
                end
            end
            SWAP_OUT: if (MemGnt) cnt_d = cnt_q + 1'b1;
            SWAP_IN: if (MemGnt) begin
                cnt_d      = cnt_q + 1'b1;
                data_we    = 1'b1;
                data_wword = cnt_q;
                data_wdata = MemRdData;
            end
            SWAP_IN_OK: begin
                tag_we           = 1'b1;
                valid_d[req_set] = 1'b1;
                dirty_d[req_set] = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        RdData     = '0;
        DCacheMiss = 1'b0;
        MemRdReq   = 1'b0;
        MemWrReq   = 1'b0;
        MemAddr    = '0;
        MemWrData  = '0;
        if (CpuRstN) begin
            DCacheMiss = (state_q != IDLE) || (req && !hit);
            case (state_q)
                IDLE: if (RdReq && !WrReq && hit) RdData = data_q[req_set][req_word];
                SWAP_OUT: begin
                    MemWrReq  = 1'b1;
                    MemAddr   = {tag_q[req_set], req_set, cnt_q, 2'b00};
                    MemWrData = data_q[req_set][cnt_q];
                end
                SWAP_IN: begin
                    MemRdReq = 1'b1;
                    MemAddr  = {req_tag, req_set, cnt_q, 2'b00};
                end
                default: ;
            endcase
        end
    end
endmodule
